// File: rtl/cache_line_fill.sv
// Line-fill engine: gathers BEATS sequential memory beats into one cache line
// and hands it to the data array with a single-cycle write strobe.
module cache_line_fill #(
   parameter int LINE_BITS = 256,
   parameter int BEAT_BITS = 32,
   parameter int BEATS     = 8,
   parameter int ADDR_BITS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fillStart,
   input  logic [ADDR_BITS-1:0] fillAddr,
   input  logic                 fillAbort,
   output logic                 memReq,
   output logic [ADDR_BITS-1:0] memAddr,
   input  logic                 memValid,
   input  logic [BEAT_BITS-1:0] memData,
   output logic [LINE_BITS-1:0] lineData,
   output logic                 regWrite,
   output logic                 busy,
   output logic                 fillDone
);

   localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFS_BITS = $clog2(LINE_BITS / 8);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [CNT_BITS-1:0]               beat_cnt;
   logic [BEATS-1:0][BEAT_BITS-1:0]   line_q;
   logic                              last_beat;

   assign last_beat = (beat_cnt == LAST_BEAT);
   assign lineData  = line_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Abort wins over a beat arriving in the same cycle; WRITE always completes.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (fillStart) begin
               next_state = FILL;
            end
         end
         FILL: begin
            if (fillAbort) begin
               next_state = IDLE;
            end else if (memValid && last_beat) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      memReq   = 1'b0;
      busy     = 1'b0;
      regWrite = 1'b0;
      fillDone = 1'b0;
      unique case (state)
         FILL: begin
            memReq = 1'b1;
            busy   = 1'b1;
         end
         WRITE: begin
            busy     = 1'b1;
            regWrite = 1'b1;
            fillDone = 1'b1;
         end
         default: begin
            memReq = 1'b0;
         end
      endcase
   end

   // Only the slice addressed by the beat counter is written, so an aborted
   // fill leaves the rest of the previous line untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memAddr  <= '0;
         beat_cnt <= '0;
         line_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fillStart) begin
                  memAddr  <= {fillAddr[ADDR_BITS-1:OFS_BITS], {OFS_BITS{1'b0}}};
                  beat_cnt <= '0;
               end
            end
            FILL: begin
               if (fillAbort) begin
                  beat_cnt <= '0;
               end else if (memValid) begin
                  line_q[beat_cnt] <= memData;
                  beat_cnt         <= last_beat ? '0 : beat_cnt + 1'b1;
               end
            end
            default: begin
               beat_cnt <= beat_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: a transaction-level model is checked
// every cycle, plus literal expectations for each scenario.
module tb_cache_line_fill;

   logic         clk;
   logic         reset;
   logic         fillStart;
   logic [31:0]  fillAddr;
   logic         fillAbort;
   logic         memReq;
   logic [31:0]  memAddr;
   logic         memValid;
   logic [31:0]  memData;
   logic [255:0] lineData;
   logic         regWrite;
   logic         busy;
   logic         fillDone;

   cache_line_fill dut (
      .clk       (clk),
      .reset     (reset),
      .fillStart (fillStart),
      .fillAddr  (fillAddr),
      .fillAbort (fillAbort),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memValid  (memValid),
      .memData   (memData),
      .lineData  (lineData),
      .regWrite  (regWrite),
      .busy      (busy),
      .fillDone  (fillDone)
   );

   int compares = 0;
   int fails    = 0;
   int cyc      = 0;

   int wr_count     = 0;
   int wr_cyc       = -1;
   int memreq_count = 0;

   // Model state: a fill is either collecting beats, or its line is pending write.
   bit          m_active = 0;
   bit          m_write  = 0;
   int          m_beats  = 0;
   logic [31:0] m_addr   = '0;
   logic [31:0] m_line [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
      compares++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [31:0] a, input logic ab,
                        input logic v, input logic [31:0] d);
      @(posedge clk);
      #1;
      fillStart = s;
      fillAddr  = a;
      fillAbort = ab;
      memValid  = v;
      memData   = d;
   endtask

   task automatic apply_stimulus_idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic apply_stimulus_beat(input logic [31:0] d);
      drive(1'b0, 32'h0, 1'b0, 1'b1, d);
   endtask

   initial begin
      foreach (m_line[i]) m_line[i] = '0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_active = 0;
            m_write  = 0;
            m_beats  = 0;
            m_addr   = '0;
            foreach (m_line[i]) m_line[i] = '0;
         end else if (clk) begin
            cyc = cyc + 1;
            if (m_write) begin
               m_write = 0;
            end else if (m_active) begin
               if (fillAbort) begin
                  m_active = 0;
                  m_beats  = 0;
               end else if (memValid) begin
                  m_line[m_beats] = memData;
                  m_beats = m_beats + 1;
                  if (m_beats == 8) begin
                     m_active = 0;
                     m_write  = 1;
                     m_beats  = 0;
                  end
               end
            end else if (fillStart) begin
               m_active = 1;
               m_beats  = 0;
               m_addr   = fillAddr & 32'hFFFF_FFE0;
            end
         end
      end
   end

   initial begin
      logic [255:0] exp_line;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = m_line[i];
         check_output("memReq",   {255'b0, memReq},   {255'b0, m_active});
         check_output("busy",     {255'b0, busy},     {255'b0, m_active | m_write});
         check_output("regWrite", {255'b0, regWrite}, {255'b0, m_write});
         check_output("fillDone", {255'b0, fillDone}, {255'b0, m_write});
         check_output("memAddr",  {224'b0, memAddr},  {224'b0, m_addr});
         check_output("lineData", lineData, exp_line);
         if (regWrite === 1'b1) begin
            wr_count = wr_count + 1;
            wr_cyc   = cyc;
         end
         if (memReq === 1'b1) memreq_count = memreq_count + 1;
      end
   end

   initial begin
      int start_cyc;
      int wr0;
      int mr0;
      fillStart = 0;
      fillAddr  = '0;
      fillAbort = 0;
      memValid  = 0;
      memData   = '0;
      reset     = 1'b0;

      // 1: reset
      #7;
      check_output("rst_memReq",   {255'b0, memReq},   256'd0);
      check_output("rst_memAddr",  {224'b0, memAddr},  256'd0);
      check_output("rst_lineData", lineData,           256'd0);
      check_output("rst_busy",     {255'b0, busy},     256'd0);
      check_output("rst_regWrite", {255'b0, regWrite}, 256'd0);
      check_output("rst_fillDone", {255'b0, fillDone}, 256'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      apply_stimulus_idle(5);
      #2;
      check_output("idle_memReq",   {255'b0, memReq},   256'd0);
      check_output("idle_regWrite", {255'b0, regWrite}, 256'd0);

      // 2: back-to-back fill
      wr0 = wr_count;
      drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
      start_cyc = cyc;
      for (int i = 1; i <= 8; i++) apply_stimulus_beat(32'h1111_1111 * i);
      apply_stimulus_idle(2);
      @(negedge clk);
      #2;
      check_output("t2_memAddr",  {224'b0, memAddr}, {224'b0, 32'h0000_1220});
      check_output("t2_lineData", lineData,
         256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
      check_output("t2_wr_count",  wr_count - wr0,     1);
      check_output("t2_wr_cycle",  wr_cyc - start_cyc, 9);
      check_output("t2_idle_busy", {255'b0, busy},     256'd0);

      // 3: stalled beats
      wr0 = wr_count;
      mr0 = memreq_count;
      drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
      start_cyc = cyc;
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus_beat(32'h1111_1111 * i);
         if (i == 2 || i == 5) apply_stimulus_idle(3);
      end
      apply_stimulus_idle(3);
      #2;
      check_output("t3_lineData", lineData,
         256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
      check_output("t3_wr_cycle",  wr_cyc - start_cyc,  15);
      check_output("t3_wr_count",  wr_count - wr0,      1);
      check_output("t3_memreq",    memreq_count - mr0,  14);

      // 4: abort together with beat 4, then a normal fill
      wr0 = wr_count;
      drive(1'b1, 32'h4000_0044, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) apply_stimulus_beat(32'hA000_0000 + i);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      apply_stimulus_idle(1);
      #2;
      check_output("t4_busy",    {255'b0, busy},               256'd0);
      check_output("t4_slice4",  {224'b0, lineData[159:128]},  {224'b0, 32'h5555_5555});
      check_output("t4_line",    lineData,
         256'h88888888_77777777_66666666_55555555_A0000003_A0000002_A0000001_A0000000);
      check_output("t4_memAddr", {224'b0, memAddr},           {224'b0, 32'h4000_0040});
      apply_stimulus_idle(1);
      drive(1'b1, 32'h0000_00FF, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) apply_stimulus_beat(32'hC000_0000 + i);
      apply_stimulus_idle(2);
      #2;
      check_output("t4_wr_count", wr_count - wr0, 1);
      check_output("t4_refill", lineData,
         256'hC0000007_C0000006_C0000005_C0000004_C0000003_C0000002_C0000001_C0000000);
      check_output("t4_refill_addr", {224'b0, memAddr}, {224'b0, 32'h0000_00E0});

      // 5: start during FILL is ignored
      wr0 = wr_count;
      drive(1'b1, 32'h0000_2010, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus_beat(32'hB000_0000 + i);
         if (i == 1) drive(1'b1, 32'hFFFF_FFE0, 1'b0, 1'b0, 32'h0);
      end
      apply_stimulus_idle(4);
      #2;
      check_output("t5_memAddr",  {224'b0, memAddr}, {224'b0, 32'h0000_2000});
      check_output("t5_wr_count", wr_count - wr0,     1);
      check_output("t5_line", lineData,
         256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000);

      // 6: reset mid-fill
      wr0 = wr_count;
      drive(1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) apply_stimulus_beat(32'hD000_0000 + i);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #2 reset = 1'b0;
      #1;
      check_output("t6_lineData", lineData,          256'd0);
      check_output("t6_busy",     {255'b0, busy},    256'd0);
      check_output("t6_memReq",   {255'b0, memReq},  256'd0);
      check_output("t6_memAddr",  {224'b0, memAddr}, 256'd0);
      apply_stimulus_idle(2);
      reset = 1'b1;
      apply_stimulus_idle(6);
      #2;
      check_output("t6_wr_count", wr_count - wr0, 0);
      check_output("t6_busy_after", {255'b0, busy}, 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
